// File: rtl/word_loader.sv
// word_loader: serial-to-parallel loader that assembles WIDTH bits and emits a one-cycle write strobe with the word on D.
// Optional even-parity checking is enabled by defining WORD_LOADER_PARITY_EN.
`default_nettype none

module word_loader #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] RST       = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       abort,
  input  logic                       s_valid,
  input  logic                       s_bit,
  output logic                       s_ready,
  output logic                       we,
  output logic [WIDTH-1:0]           D,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       busy,
  output logic                       err
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    PAR    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  r_d;
  logic [CW-1:0]     r_count;
  logic              r_ready;
  logic              r_err;
  logic              w_accept;
  logic [WIDTH-1:0]  w_shift_next;

  assign w_accept     = s_valid & r_ready;
  assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], s_bit}
                                  : {s_bit, r_shift[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SHIFT;
      r_shift <= '0;
      r_d     <= RST;
      r_count <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= 1'b0;
      case (r_state)
        SHIFT: begin
          if (abort) begin
            r_count <= '0;
            r_shift <= '0;
          end else if (w_accept) begin
            r_shift <= w_shift_next;
            r_count <= r_count + 1'b1;
            if (r_count == C_LAST) begin
`ifdef WORD_LOADER_PARITY_EN
              r_state <= PAR;
`else
              r_state <= COMMIT;
              r_d     <= w_shift_next;
              r_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef WORD_LOADER_PARITY_EN
        PAR: begin
          if (abort) begin
            r_state <= SHIFT;
            r_count <= '0;
            r_shift <= '0;
          end else if (w_accept) begin
            // Even parity: the extra bit must equal the XOR of the data bits.
            if (s_bit == ^r_shift) begin
              r_state <= COMMIT;
              r_d     <= r_shift;
              r_ready <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= SHIFT;
              r_count <= '0;
              r_shift <= '0;
            end
          end
        end
`endif
        COMMIT: begin
          r_state <= SHIFT;
          r_count <= '0;
          r_shift <= '0;
        end
        default: begin
          r_state <= SHIFT;
          r_count <= '0;
          r_shift <= '0;
        end
      endcase
    end
  end

  // we is decoded from state so an asynchronous reset drops it immediately.
  assign we      = (r_state == COMMIT);
  assign s_ready = r_ready;
  assign D       = r_d;
  assign count   = r_count;
  assign busy    = (r_count != '0) || (r_state != SHIFT);

`ifdef WORD_LOADER_PARITY_EN
  assign err = r_err;
`else
  assign err = 1'b0;
  logic w_unused;
  assign w_unused = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_word_loader.sv
// tb_word_loader: directed self-checking bench for word_loader (MSB-first and LSB-first instances).
// Parity cases run when WORD_LOADER_PARITY_EN is defined.
`default_nettype none

module tb_word_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, abort, s_valid, s_bit;
  logic         s_ready, we, busy, err;
  logic [W-1:0] D;
  logic [3:0]   count;
  logic         s_ready_l, we_l, busy_l, err_l;
  logic [W-1:0] D_l;
  logic [3:0]   count_l;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int err_cnt  = 0;
  int base;

  word_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .abort(abort), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready), .we(we), .D(D), .count(count), .busy(busy), .err(err)
  );

  word_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .abort(abort), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready_l), .we(we_l), .D(D_l), .count(count_l), .busy(busy_l), .err(err_l)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) we_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_bit   = b;
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [7:0] w);
    send_data(w);
`ifdef WORD_LOADER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    rst = 1'b0; abort = 1'b0; s_valid = 1'b0; s_bit = 1'b0;
    repeat (3) step();
    check("rst we", we, 0);
    check("rst D", D, 8'h00);
    check("rst count", count, 0);
    check("rst s_ready", s_ready, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    rst = 1'b1;
    step();
    check("release s_ready", s_ready, 1);

    // Back-to-back word 1,0,1,0,0,1,1,0
    base = we_cnt;
    send_word(8'hA6);
    check("t2 we", we, 1);
    check("t2 D msb", D, 8'hA6);
    check("t2 D lsb", D_l, 8'h65);
    check("t2 s_ready commit", s_ready, 0);
    check("t2 busy commit", busy, 1);
    step();
    check("t2 we drop", we, 0);
    check("t2 count clr", count, 0);
    check("t2 busy idle", busy, 0);
    check("t2 D hold", D, 8'hA6);
    check("t2 we pulses", we_cnt - base, 1);

    // Reset after three accepted bits
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t1 count3", count, 3);
    rst = 1'b0;
    #1;
    check("t1 we", we, 0);
    check("t1 D", D, 8'h00);
    check("t1 count", count, 0);
    check("t1 s_ready", s_ready, 0);
    #2 rst = 1'b1;
    step();
    check("t1 s_ready after", s_ready, 1);

    // Reset during COMMIT
    send_word(8'h5A);
    check("rc we", we, 1);
    check("rc D", D, 8'h5A);
    rst = 1'b0;
    #1;
    check("rc we async", we, 0);
    check("rc D", D, 8'h00);
    check("rc D lsb", D_l, 8'h00);
    #2 rst = 1'b1;
    step();

    // Gaps of two idle cycles after bits 3 and 6
    base = we_cnt;
    begin
      logic [7:0] pat;
      pat = 8'hA6;
      for (int i = 0; i < 8; i++) begin
        send_bit(pat[7-i]);
        if (i == 2 || i == 5) begin
          step(); step();
          check("t3 gap count", count, i + 1);
        end
      end
    end
`ifdef WORD_LOADER_PARITY_EN
    send_bit(1'b0);
`endif
    check("t3 D", D, 8'hA6);
    check("t3 we", we, 1);
    step();
    check("t3 we pulses", we_cnt - base, 1);

    // Abort after five bits, dropped bit not counted
    base = we_cnt;
    repeat (5) send_bit(1'b1);
    check("t4 count5", count, 5);
    abort = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b0;
    check("t4 count abort", count, 0);
    check("t4 busy abort", busy, 0);
    check("t4 no we", we_cnt - base, 0);
    send_word(8'hFF);
    check("t4 D", D, 8'hFF);
    step();
    check("t4 we pulses", we_cnt - base, 1);

    // s_valid held across two words
    base = we_cnt;
    send_word(8'h3C);
    check("t5 D1", D, 8'h3C);
    check("t5 s_ready commit", s_ready, 0);
    s_valid = 1'b1; s_bit = 1'b1;
    step();
    check("t5 count after commit", count, 0);
    check("t5 s_ready after commit", s_ready, 1);
    check("t5 we after commit", we, 0);
    send_word(8'hC5);
    check("t5 D2 msb", D, 8'hC5);
    check("t5 D2 lsb", D_l, 8'hA3);
    step();
    check("t5 we pulses", we_cnt - base, 2);

`ifdef WORD_LOADER_PARITY_EN
    base = we_cnt;
    send_data(8'hA6);
    check("t6 busy in par", busy, 1);
    send_bit(1'b0);
    check("t6 good we", we, 1);
    check("t6 good D", D, 8'hA6);
    step();
    send_data(8'hA6);
    send_bit(1'b1);
    check("t6 bad err", err, 1);
    check("t6 bad we", we, 0);
    check("t6 bad D", D, 8'hA6);
    check("t6 bad count", count, 0);
    step();
    check("t6 err pulse", err, 0);
    check("t6 we pulses", we_cnt - base, 1);
    check("t6 err pulses", err_cnt, 1);
`else
    check("no-parity err count", err_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
